seg7_scan_scheduler: RTL and testbench

//   Sequences the 4-digit seven-segment display datapath. Accepts a binary count

---
 rtl/seg7_scan_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_seg7_scan_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_scheduler.sv
// Four-digit seven-segment driver: handshake intake, shift-add-3 BCD converter
// with a one-deep pending slot, and a free-running blanked digit scanner.
module seg7_scan_scheduler #(
  parameter int WIDTH        = 14,
  parameter int SCAN_DIV     = 35000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] value,
  input  logic             value_valid,
  output logic             ready,
  input  logic             blank_zero,
  output logic             bcd_valid,
  output logic             sat,
  output logic [7:0]       seg7,
  output logic [3:0]       seg7_sel
);

  // state  | meaning
  // IDLE   | converter free, ready=1, waiting for value_valid
  // SHIFT  | WIDTH shift-add-3 iterations in progress
  // COMMIT | publish BCD to digits, chain into pending value if any
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t state, state_next;

  logic [WIDTH-1:0] shreg;
  logic [15:0]      bcd;
  logic [BW-1:0]    bit_cnt;
  logic             sat_next;
  logic [15:0]      digits;
  logic             pending;
  logic [WIDTH-1:0] pend_val;

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             shift_en;
  logic             commit;
  logic             pend_set;
  logic             pend_clr;

  logic [CW-1:0]    slot_cnt;
  logic [1:0]       scan_idx;
  logic [7:0]       seg_d;
  logic [3:0]       sel_d;
  logic [3:0]       digit_cur;
  logic             higher_zero;

  function automatic logic [15:0] dabble(input logic [15:0] cur, input logic bit_in);
    logic [15:0] adj;
    adj = cur;
    for (int n = 0; n < 4; n++) begin
      if (adj[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = adj[n*4 +: 4] + 4'd3;
    end
    return {adj[14:0], bit_in};
  endfunction

  function automatic logic [7:0] decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_val   = '0;
    shift_en   = 1'b0;
    commit     = 1'b0;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (value_valid) begin
          load       = 1'b1;
          load_val   = value;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        pend_set = value_valid;
        if (bit_cnt == '0) state_next = COMMIT;
      end
      COMMIT: begin
        commit = 1'b1;
        // A value offered during COMMIT is newer than anything pending.
        if (value_valid) begin
          load       = 1'b1;
          load_val   = value;
          pend_clr   = 1'b1;
          state_next = SHIFT;
        end else if (pending) begin
          load       = 1'b1;
          load_val   = pend_val;
          pend_clr   = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      sat_next  <= 1'b0;
      digits    <= '0;
      sat       <= 1'b0;
      bcd_valid <= 1'b0;
      pending   <= 1'b0;
      pend_val  <= '0;
    end else begin
      bcd_valid <= commit;
      if (commit) begin
        digits <= bcd;
        sat    <= sat_next;
      end
      if (load) begin
        if (32'(load_val) > 32'd9999) begin
          shreg    <= WIDTH'(9999);
          sat_next <= 1'b1;
        end else begin
          shreg    <= load_val;
          sat_next <= 1'b0;
        end
        bcd     <= '0;
        bit_cnt <= BW'(WIDTH - 1);
      end else if (shift_en) begin
        bcd     <= dabble(bcd, shreg[WIDTH-1]);
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt - 1'b1;
      end
      if (pend_set) begin
        pending  <= 1'b1;
        pend_val <= value;
      end else if (pend_clr) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      scan_idx <= '0;
    end else if (slot_cnt == CW'(SCAN_DIV - 1)) begin
      slot_cnt <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  always_comb begin
    digit_cur = digits[scan_idx*4 +: 4];
    case (scan_idx)
      2'd1:    higher_zero = (digits[15:4] == 12'd0);
      2'd2:    higher_zero = (digits[15:8] == 8'd0);
      2'd3:    higher_zero = (digits[15:12] == 4'd0);
      default: higher_zero = 1'b0;
    endcase
  end

  always_comb begin
    seg_d = 8'h00;
    sel_d = 4'b0000;
    if (slot_cnt >= CW'(BLANK_CYCLES)) begin
      sel_d = 4'b0001 << scan_idx;
      if (!(blank_zero && higher_zero)) seg_d = decode(digit_cur);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg7     <= 8'h00;
      seg7_sel <= 4'b0000;
    end else begin
      seg7     <= seg_d;
      seg7_sel <= sel_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Bench for seg7_scan_scheduler: arithmetic reference model checked every cycle
// plus literal expectations for the directed scenarios.
module tb_seg7_scan_scheduler;

  localparam int WIDTH = 14;
  localparam int SD    = 20;
  localparam int BLK   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] value = '0;
  logic             value_valid = 1'b0;
  logic             ready;
  logic             blank_zero = 1'b0;
  logic             bcd_valid;
  logic             sat;
  logic [7:0]       seg7;
  logic [3:0]       seg7_sel;

  seg7_scan_scheduler #(.WIDTH(WIDTH), .SCAN_DIV(SD), .BLANK_CYCLES(BLK)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid),
    .ready(ready), .blank_zero(blank_zero), .bcd_valid(bcd_valid), .sat(sat),
    .seg7(seg7), .seg7_sel(seg7_sel)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int bv_count = 0;
  int rdy_low = 0;

  logic [7:0] tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  int pow10 [4] = '{1, 10, 100, 1000};

  // reference model state
  int m_busy, m_cur, m_pend_v, m_disp, scan_t;
  bit m_cur_sat, m_pend, m_sat, m_bv;
  logic [7:0] e_seg;
  logic [3:0] e_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int satv(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  task automatic model_start(input int v);
    m_cur     = satv(v);
    m_cur_sat = (v > 9999);
    m_busy    = WIDTH + 1;
  endtask

  task automatic model_edge();
    int pos, k, d;
    if (!rst_n) begin
      m_busy = 0; m_pend = 0; m_disp = 0; m_sat = 0; m_bv = 0; scan_t = 0;
      e_seg = 8'h00; e_sel = 4'b0000;
      return;
    end
    pos = scan_t % SD;
    k = (scan_t / SD) % 4;
    scan_t++;
    e_seg = 8'h00; e_sel = 4'b0000;
    if (pos >= BLK) begin
      e_sel = 4'(1 << k);
      d = (m_disp / pow10[k]) % 10;
      if (!(blank_zero && k > 0 && m_disp < pow10[k])) e_seg = tbl[d];
    end
    m_bv = 0;
    if (m_busy == 0) begin
      if (value_valid) model_start(int'(value));
    end else if (m_busy == 1) begin
      m_disp = m_cur; m_sat = m_cur_sat; m_bv = 1;
      if (value_valid) begin model_start(int'(value)); m_pend = 0; end
      else if (m_pend) begin model_start(m_pend_v); m_pend = 0; end
      else m_busy = 0;
    end else begin
      m_busy--;
      if (value_valid) begin m_pend = 1; m_pend_v = int'(value); end
    end
  endtask

  task automatic offer(input int v);
    @(negedge clk);
    value = WIDTH'(v);
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready) begin ok = 1; break; end
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic expect_sel(input string name, input logic [3:0] s, input logic [7:0] seg);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (seg7_sel == s) begin ok = 1; break; end
    end
    check({name, "_found"}, 32'(ok), 32'd1);
    check(name, 32'(seg7), 32'(seg));
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int bv0, rl0;
    fork
      forever begin
        @(posedge clk);
        model_edge();
        #1;
        check("seg7", 32'(seg7), 32'(e_seg));
        check("seg7_sel", 32'(seg7_sel), 32'(e_sel));
        check("ready", 32'(ready), 32'(m_busy == 0));
        check("bcd_valid", 32'(bcd_valid), 32'(m_bv));
        check("sat", 32'(sat), 32'(m_sat));
        if (bcd_valid) bv_count++;
        if (!ready) rdy_low++;
      end
    join_none

    // 1: reset and first slot
    run(3);
    check("rst_seg7", 32'(seg7), 32'h0);
    check("rst_sel", 32'(seg7_sel), 32'h0);
    check("rst_ready", 32'(ready), 32'd1);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2 check("blank_slot0", 32'(seg7_sel), 32'h0);
    @(posedge clk);
    #2 check("slot0_sel", 32'(seg7_sel), 32'h1);
    check("slot0_seg", 32'(seg7), 32'h3F);

    // 2: 1234
    bv0 = bv_count; rl0 = rdy_low;
    offer(1234);
    wait_idle();
    run(2);
    check("t2_ready_low", 32'(rdy_low - rl0), 32'd15);
    check("t2_bv_pulses", 32'(bv_count - bv0), 32'd1);
    expect_sel("t2_ones", 4'b0001, 8'h66);
    expect_sel("t2_tens", 4'b0010, 8'h4F);
    expect_sel("t2_hund", 4'b0100, 8'h5B);
    expect_sel("t2_thou", 4'b1000, 8'h06);

    // 3: saturation then clear
    offer(12000);
    wait_idle();
    run(1);
    check("t3_sat_on", 32'(sat), 32'd1);
    expect_sel("t3_thou9", 4'b1000, 8'h6F);
    offer(42);
    wait_idle();
    run(1);
    check("t3_sat_off", 32'(sat), 32'd0);
    expect_sel("t3_tens4", 4'b0010, 8'h66);
    expect_sel("t3_thou0", 4'b1000, 8'h3F);

    // 4: leading-zero suppression
    offer(7);
    wait_idle();
    @(negedge clk) blank_zero = 1'b1;
    expect_sel("t4_hund_blank", 4'b0100, 8'h00);
    expect_sel("t4_thou_blank", 4'b1000, 8'h00);
    expect_sel("t4_ones", 4'b0001, 8'h07);
    @(negedge clk) blank_zero = 1'b0;
    expect_sel("t4_tens_shown", 4'b0010, 8'h3F);
    expect_sel("t4_thou_shown", 4'b1000, 8'h3F);

    // 5: pending value while busy
    bv0 = bv_count;
    offer(5);
    offer(8);
    run(3);
    wait_idle();
    run(2);
    check("t5_bv_pulses", 32'(bv_count - bv0), 32'd2);
    expect_sel("t5_ones8", 4'b0001, 8'h7F);

    // 6: async reset mid-conversion
    offer(9);
    wait_idle();
    expect_sel("t6_ones9", 4'b0001, 8'h6F);
    offer(3);
    run(4);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_seg7", 32'(seg7), 32'h0);
    check("t6_rst_sel", 32'(seg7_sel), 32'h0);
    check("t6_rst_ready", 32'(ready), 32'd1);
    check("t6_rst_bv", 32'(bcd_valid), 32'd0);
    run(3);
    rst_n = 1'b1;
    expect_sel("t6_ones_cleared", 4'b0001, 8'h3F);
    run(2 * 4 * SD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
